johnson_phase_monitor: RTL
==========================

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 Parameter: CNT_W, 8, width of the revolution and error counters.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: sync_reset_n  input  1  reset, synchronous, active-low.
REQ-004 Port: cnt_reset  input  1  active-high copy of the upstream 4-bit Johnson counter's reset; forces re-acquisition without fault.
REQ-005 Port: johnson_in  input  4  upstream Johnson count. Upstream changes it on the falling edge of clk and advances it every cycle.
REQ-006 Port: phase  output  3  decoded phase 0..7.
REQ-007 Port: phase_onehot  output  8  one-hot of phase; all zero when phase_valid=0.
REQ-008 Port: phase_valid  output  1  registered code was legal.
REQ-009 Port: locked  output  1  FSM in LOCKED.
REQ-010 Port: fault  output  1  one-cycle pulse on sequence violation.
REQ-011 Port: rev_count  output  CNT_W  completed revolutions (7->0 wraps), saturating.
REQ-012 Port: err_count  output  CNT_W  faults detected, saturating.

Function
REQ-013 Legal code map SHALL be 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; the other 8 codes are illegal.
REQ-014 johnson_in SHALL be captured into a capture register at rising edge N; the capture register SHALL drive phase, phase_valid and phase_onehot directly. All other outputs SHALL update at edge N+1 from the captured code, giving 1-cycle decode latency.
REQ-015 FSM states: ACQUIRE, LOCKED, FAULT; encoding from the package.
REQ-016 ACQUIRE: on a legal captured code -> LOCKED, with expected = (phase+1) mod 8. On an illegal code, stay.
REQ-017 LOCKED, captured phase == expected: stay, and advance expected by 1 mod 8. If the captured phase is 0 and the previous phase was 7, rev_count SHALL increment.
REQ-018 LOCKED, illegal code or phase != expected: go to FAULT, pulse fault for exactly 1 cycle, and increment err_count.
REQ-019 FAULT SHALL last exactly 1 cycle and then unconditionally go to ACQUIRE.
REQ-020 cnt_reset=1 SHALL force ACQUIRE from any state, with no fault and no counter change. It has priority over REQ-016..REQ-019.
REQ-021 rev_count and err_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 locked SHALL be 1 only in LOCKED; fault SHALL never be 1 in two consecutive cycles.
REQ-023 The first lock after ACQUIRE SHALL NOT increment rev_count, even when locking on phase 0.

Reset
REQ-024 sync_reset_n=0 at a rising edge SHALL set: capture register to 0000, state to ACQUIRE, expected to 0, all outputs to 0.
REQ-025 sync_reset_n SHALL have priority over cnt_reset and all other inputs. Reset mid-revolution SHALL discard partial progress.

Structure
REQ-026 Package johnson_pkg SHALL hold: the FSM state typedef, PHASE_W=3, CODE_W=4, and the 8 legal code constants.
REQ-027 Combinational sub-module johnson_phase_decode SHALL map 4-bit code -> {legal, phase[2:0]}.
REQ-028 There SHALL be no falling-edge or latch-based logic inside the block.

Verification
REQ-029 Reset, then feed the legal sequence from 0000 for 17 cycles -> locked=1 from the 3rd edge; rev_count=2; fault never asserted.
REQ-030 While LOCKED at phase 3, inject 0101 for one cycle -> fault pulse for 1 cycle; err_count=1; locked=0; relock on the next legal code.
REQ-031 While LOCKED, skip a phase (0011 then 1111) -> fault=1 once; err_count increments; back in ACQUIRE 1 cycle later.
REQ-032 Assert cnt_reset with johnson_in held at 0000 for 5 cycles -> no fault; locked=0 during assertion; locked=1 again 2 edges after release.
REQ-033 With CNT_W=2, run 5 revolutions -> rev_count holds 3. Force 5 faults -> err_count holds 3.
REQ-034 Drop sync_reset_n mid-revolution while LOCKED -> all outputs 0 on the next edge; counters cleared; re-acquisition behaves as in REQ-029.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson counter phase monitor.
// The legal code table is ordered by phase so the index is the decoded phase.
package johnson_pkg;

    localparam int PHASE_W    = 3;
    localparam int CODE_W     = 4;
    localparam int NUM_PHASES = 8;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] CODE_P0 = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_P1 = 4'b0001;
    localparam logic [CODE_W-1:0] CODE_P2 = 4'b0011;
    localparam logic [CODE_W-1:0] CODE_P3 = 4'b0111;
    localparam logic [CODE_W-1:0] CODE_P4 = 4'b1111;
    localparam logic [CODE_W-1:0] CODE_P5 = 4'b1110;
    localparam logic [CODE_W-1:0] CODE_P6 = 4'b1100;
    localparam logic [CODE_W-1:0] CODE_P7 = 4'b1000;

    localparam logic [CODE_W-1:0] LEGAL_CODES [NUM_PHASES] = '{
        CODE_P0, CODE_P1, CODE_P2, CODE_P3,
        CODE_P4, CODE_P5, CODE_P6, CODE_P7
    };

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational map from a 4-bit Johnson code to {legal, phase}.
// Illegal codes report phase 0 with legal low.
module johnson_phase_decode
    import johnson_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic               legal,
    output logic [PHASE_W-1:0] phase
);

    logic [NUM_PHASES-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_match
            assign hit[gi] = (code == LEGAL_CODES[gi]);
        end
    endgenerate

    always_comb begin
        legal = |hit;
        phase = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (hit[i]) begin
                phase = PHASE_W'(i);
            end
        end
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks an upstream 4-bit Johnson counter: decodes its phase, checks that it
// advances by one every cycle, and counts revolutions and sequence faults.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic                  cnt_reset,
    input  logic [CODE_W-1:0]     johnson_in,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  phase_valid,
    output logic                  locked,
    output logic                  fault,
    output logic [CNT_W-1:0]      rev_count,
    output logic [CNT_W-1:0]      err_count
);

    logic [CODE_W-1:0]  code_reg;
    logic               cap_valid_reg;
    logic               cnt_reset_reg;
    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] expected_reg, expected_next;
    logic [PHASE_W-1:0] prev_phase_reg, prev_phase_next;
    logic [CNT_W-1:0]   rev_reg, rev_next;
    logic [CNT_W-1:0]   err_reg, err_next;

    logic               dec_legal;
    logic [PHASE_W-1:0] dec_phase;
    logic               code_legal;
    logic               rev_inc;
    logic               err_inc;

    johnson_phase_decode u_decode (
        .code  (code_reg),
        .legal (dec_legal),
        .phase (dec_phase)
    );

    // The reset value 0000 is itself legal, so cap_valid_reg keeps the
    // outputs quiet until a real sample has been taken.
    assign code_legal  = cap_valid_reg && dec_legal;
    assign phase_valid = code_legal;
    assign phase       = code_legal ? dec_phase : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_onehot
            assign phase_onehot[gi] = code_legal && (dec_phase == PHASE_W'(gi));
        end
    endgenerate

    assign locked    = (state_reg == ST_LOCKED);
    assign fault     = (state_reg == ST_FAULT);
    assign rev_count = rev_reg;
    assign err_count = err_reg;

    // cnt_reset is pipelined with the code so both reach the FSM together.
    always_comb begin
        state_next      = state_reg;
        expected_next   = expected_reg;
        prev_phase_next = code_legal ? dec_phase : prev_phase_reg;
        rev_inc         = 1'b0;
        err_inc         = 1'b0;

        if (cnt_reset_reg) begin
            state_next = ST_ACQUIRE;
        end else begin
            case (state_reg)
                ST_ACQUIRE: begin
                    if (code_legal) begin
                        state_next    = ST_LOCKED;
                        expected_next = dec_phase + PHASE_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (code_legal && (dec_phase == expected_reg)) begin
                        expected_next = expected_reg + PHASE_W'(1);
                        if ((dec_phase == '0) &&
                            (prev_phase_reg == PHASE_W'(NUM_PHASES - 1))) begin
                            rev_inc = 1'b1;
                        end
                    end else begin
                        state_next = ST_FAULT;
                        err_inc    = 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_ACQUIRE;
                end
                default: begin
                    state_next = ST_ACQUIRE;
                end
            endcase
        end

        rev_next = (rev_inc && (rev_reg != '1)) ? rev_reg + CNT_W'(1) : rev_reg;
        err_next = (err_inc && (err_reg != '1)) ? err_reg + CNT_W'(1) : err_reg;
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            code_reg       <= '0;
            cap_valid_reg  <= 1'b0;
            cnt_reset_reg  <= 1'b0;
            state_reg      <= ST_ACQUIRE;
            expected_reg   <= '0;
            prev_phase_reg <= '0;
            rev_reg        <= '0;
            err_reg        <= '0;
        end else begin
            code_reg       <= johnson_in;
            cap_valid_reg  <= 1'b1;
            cnt_reset_reg  <= cnt_reset;
            state_reg      <= state_next;
            expected_reg   <= expected_next;
            prev_phase_reg <= prev_phase_next;
            rev_reg        <= rev_next;
            err_reg        <= err_next;
        end
    end

endmodule
